mem_access_unit: RTL and testbench

- Multicycle memory-interface stage directly downstream of the processor controller/datapath.
- Converts the single-cycle memory strobe (address, write data, write enable, access size) into a request/acknowledge bus transaction.
- Generates byte enables and lane-shifted write data, and aligns/extends load data for the data register.
- Holds the controller with a stall until the transaction completes, errors, or times out.

---
 rtl/mem_access_pkg.sv | 54 +++++
 rtl/mem_access_unit_load_align.sv | 61 ++++++
 rtl/mem_access_unit.sv | 166 ++++++++++++++++
 tb/tb_mem_access_unit.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// mem_access_pkg: shared types and helpers for the memory access unit.
//   state_t        - access FSM states
//   SZ_B/SZ_H/SZ_W - access size codes (2'b11 is illegal)
//   byte_enables() - lane enables for a size/low-address pair
//   misaligned()   - flags an access that cannot go to the bus
package mem_access_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } state_t;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  // Byte enables for an access of the given size starting at byte lane 'lane'.
  function automatic logic [3:0] byte_enables(input logic [1:0] size, input logic [1:0] lane);
    logic [3:0] be;
    case (size)
      SZ_B:    be = 4'b0001 << lane;
      SZ_H:    be = 4'b0011 << lane;
      SZ_W:    be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  // True for an illegal size or an address not aligned to the access size.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lane);
    logic bad;
    case (size)
      SZ_B:    bad = 1'b0;
      SZ_H:    bad = lane[0];
      SZ_W:    bad = |lane;
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  // Store data replicated across every lane the access could hit.
  function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] wd);
    logic [31:0] w;
    case (size)
      SZ_B:    w = {4{wd[7:0]}};
      SZ_H:    w = {2{wd[15:0]}};
      default: w = wd;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/mem_access_unit_load_align.sv
// load_align: combinational load formatter.
//   raw_word - raw 32-bit word from the bus
//   lane     - low two address bits of the access
//   size     - access size code
//   zext     - 1 zero-extends sub-word loads, 0 sign-extends
//   data     - right-justified, extended load result
module load_align
  import mem_access_pkg::*;
(
  input  logic [31:0] raw_word,
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic        zext,
  output logic [31:0] data
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Select the addressed byte and halfword lanes out of the raw word
  always_comb begin
    byte_s = 8'h00;
    half_s = 16'h0000;
    case (lane)
      2'd0:    byte_s = raw_word[7:0];
      2'd1:    byte_s = raw_word[15:8];
      2'd2:    byte_s = raw_word[23:16];
      2'd3:    byte_s = raw_word[31:24];
      default: byte_s = 8'h00;
    endcase
    if (lane[1]) begin
      half_s = raw_word[31:16];
    end else begin
      half_s = raw_word[15:0];
    end
  end

  // Extend the selected lane to 32 bits according to the access size
  always_comb begin
    data = 32'h0000_0000;
    case (size)
      SZ_B: begin
        if (zext) begin
          data = {24'h00_0000, byte_s};
        end else begin
          data = {{24{byte_s[7]}}, byte_s};
        end
      end
      SZ_H: begin
        if (zext) begin
          data = {16'h0000, half_s};
        end else begin
          data = {{16{half_s[15]}}, half_s};
        end
      end
      SZ_W:    data = raw_word;
      default: data = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: turns a single-cycle memory strobe from the controller
// into a req/ack bus transaction, stalling the controller meanwhile.
//   clk, reset             - clock, asynchronous active-low reset
//   req_*                  - access request (held by the controller until done/err)
//   stall                  - freezes the controller while an access is pending
//   done / err             - one-cycle completion / failure pulses
//   rdata                  - last completed load, aligned and extended
//   bus_req..bus_wdata     - request side of the memory bus
//   bus_ack/rdata/err      - response side of the memory bus
module mem_access_unit #(
  parameter int TIMEOUT = 16,
  parameter int AW      = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid,
  input  logic          req_we,
  input  logic [AW-1:0] req_adr,
  input  logic [31:0]   req_wd,
  input  logic [1:0]    req_size,
  input  logic          req_unsigned,
  output logic          stall,
  output logic          done,
  output logic          err,
  output logic [31:0]   rdata,
  output logic          bus_req,
  output logic          bus_we,
  output logic [AW-1:0] bus_adr,
  output logic [3:0]    bus_be,
  output logic [31:0]   bus_wdata,
  input  logic          bus_ack,
  input  logic [31:0]   bus_rdata,
  input  logic          bus_err
);

  import mem_access_pkg::*;

  localparam int            CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam bit            TO_EN    = (TIMEOUT != 0);

  state_t          state_r, state_s;
  logic [CW-1:0]   cnt_r;
  logic            we_r;
  logic [AW-1:0]   adr_r;
  logic [31:0]     wd_r;
  logic [1:0]      size_r;
  logic            uns_r;
  logic [31:0]     rdata_r;
  logic            latch_s;
  logic            load_s;
  logic            in_bus_s;
  logic [31:0]     fmt_s;

  assign in_bus_s = (state_r == BUS);

  load_align u_load_align (
    .raw_word (bus_rdata),
    .lane     (adr_r[1:0]),
    .size     (size_r),
    .zext     (uns_r),
    .data     (fmt_s)
  );

  // Next-state logic; bus_err outranks bus_ack, which outranks the timeout
  always_comb begin
    state_s = state_r;
    latch_s = 1'b0;
    load_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (req_valid) begin
          if (misaligned(req_size, req_adr[1:0])) begin
            state_s = ERR;
          end else begin
            state_s = BUS;
            latch_s = 1'b1;
          end
        end else begin
          state_s = IDLE;
        end
      end
      BUS: begin
        if (bus_err) begin
          state_s = ERR;
        end else if (bus_ack) begin
          state_s = DONE;
          load_s  = ~we_r;
        end else if (TO_EN && (cnt_r == CNT_LAST)) begin
          state_s = ERR;
        end else begin
          state_s = BUS;
        end
      end
      DONE:    state_s = IDLE;
      ERR:     state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Bus-wait counter: counts BUS cycles, clears whenever BUS is left
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_r <= '0;
    end else if (in_bus_s && (state_s == BUS)) begin
      cnt_r <= cnt_r + CW'(1);
    end else begin
      cnt_r <= '0;
    end
  end

  // Request capture on acceptance, so the controller strobe may change later
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      we_r   <= 1'b0;
      adr_r  <= '0;
      wd_r   <= 32'h0000_0000;
      size_r <= 2'b00;
      uns_r  <= 1'b0;
    end else if (latch_s) begin
      we_r   <= req_we;
      adr_r  <= req_adr;
      wd_r   <= req_wd;
      size_r <= req_size;
      uns_r  <= req_unsigned;
    end else begin
      we_r   <= we_r;
      adr_r  <= adr_r;
      wd_r   <= wd_r;
      size_r <= size_r;
      uns_r  <= uns_r;
    end
  end

  // Load result register; only an acknowledged load updates it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata_r <= 32'h0000_0000;
    end else if (load_s) begin
      rdata_r <= fmt_s;
    end else begin
      rdata_r <= rdata_r;
    end
  end

  assign rdata     = rdata_r;
  assign done      = (state_r == DONE);
  assign err       = (state_r == ERR);
  // reset term forces stall low while reset is held even if req_valid stays up
  assign stall     = reset & ((state_r == IDLE && req_valid) || in_bus_s);
  assign bus_req   = in_bus_s;
  assign bus_we    = in_bus_s & we_r;
  assign bus_adr   = in_bus_s ? {adr_r[AW-1:2], 2'b00} : '0;
  assign bus_be    = in_bus_s ? byte_enables(size_r, adr_r[1:0]) : 4'b0000;
  assign bus_wdata = in_bus_s ? lane_wdata(size_r, wd_r) : 32'h0000_0000;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed-vector bench for mem_access_unit (TIMEOUT=4).
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_we, req_unsigned;
  logic [31:0] req_adr, req_wd;
  logic [1:0]  req_size;
  logic        stall, done, err;
  logic [31:0] rdata;
  logic        bus_req, bus_we;
  logic [31:0] bus_adr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;
  logic        bus_ack, bus_err;

  int n_vec = 0;
  int n_bad = 0;

  // results of the last access
  int          a_stall, a_breq;
  logic        a_done, a_err, a_we;
  logic [31:0] a_adr, a_wd;
  logic [3:0]  a_be;

  always #5 clk = ~clk;

  mem_access_unit #(.TIMEOUT(4), .AW(32)) dut (
    .clk(clk), .reset(rst_n),
    .req_valid(req_valid), .req_we(req_we), .req_adr(req_adr), .req_wd(req_wd),
    .req_size(req_size), .req_unsigned(req_unsigned),
    .stall(stall), .done(done), .err(err), .rdata(rdata),
    .bus_req(bus_req), .bus_we(bus_we), .bus_adr(bus_adr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata), .bus_err(bus_err)
  );

  task automatic chk_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one access; respond with ack/err after wait_n bus cycles.
  task automatic access(input logic we, input logic [31:0] adr, input logic [31:0] wd,
                        input logic [1:0] size, input logic uns, input int wait_n,
                        input logic ack_en, input logic err_en, input logic [31:0] rd);
    logic finished;
    finished = 1'b0;
    a_stall = 0; a_breq = 0; a_done = 1'b0; a_err = 1'b0;
    a_we = 1'b0; a_adr = 32'h0; a_wd = 32'h0; a_be = 4'h0;
    req_we = we; req_adr = adr; req_wd = wd; req_size = size; req_unsigned = uns;
    req_valid = 1'b1;
    for (int c = 0; c < 40 && !finished; c++) begin
      #1;
      if (stall) a_stall++;
      if (done || err) begin
        a_done = done; a_err = err; finished = 1'b1;
      end else begin
        if (bus_req) begin
          a_breq++;
          a_we = bus_we; a_adr = bus_adr; a_wd = bus_wdata; a_be = bus_be;
          bus_ack   = ack_en && (a_breq > wait_n);
          bus_err   = err_en && (a_breq > wait_n);
          bus_rdata = rd;
        end else begin
          bus_ack = 1'b0; bus_err = 1'b0;
        end
        tick();
      end
    end
    req_valid = 1'b0; bus_ack = 1'b0; bus_err = 1'b0;
    tick();
    #1;
    chk_vec("pulse_then_idle", 32'({done, err, bus_req, stall}), 32'h0);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_adr = 32'h0; req_wd = 32'h0;
    req_size = 2'b00; req_unsigned = 1'b0; bus_ack = 1'b0; bus_err = 1'b0; bus_rdata = 32'h0;
    #2;
    chk_vec("rst_ctrl", 32'({stall, done, err, bus_req, bus_we}), 32'h0);
    chk_vec("rst_bus", bus_adr | bus_wdata | 32'(bus_be) | rdata, 32'h0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // signed byte load, lane 3, same-cycle ack
    access(1'b0, 32'h103, 32'h0, 2'b00, 1'b0, 0, 1'b1, 1'b0, 32'h80AABBCC);
    chk_vec("lb_done", 32'({a_done, a_err}), 32'h2);
    chk_vec("lb_stall", 32'(a_stall), 32'd2);
    chk_vec("lb_breq", 32'(a_breq), 32'd1);
    chk_vec("lb_adr", a_adr, 32'h100);
    chk_vec("lb_be", 32'(a_be), 32'h8);
    chk_vec("lb_we", 32'(a_we), 32'h0);
    chk_vec("lb_rdata", rdata, 32'hFFFFFF80);

    // store half at lane 2, three wait cycles (ack lands on the last counter value)
    access(1'b1, 32'h0A, 32'h1234BEEF, 2'b01, 1'b0, 3, 1'b1, 1'b0, 32'h0);
    chk_vec("sh_done", 32'({a_done, a_err}), 32'h2);
    chk_vec("sh_breq", 32'(a_breq), 32'd4);
    chk_vec("sh_we", 32'(a_we), 32'h1);
    chk_vec("sh_adr", a_adr, 32'h08);
    chk_vec("sh_be", 32'(a_be), 32'hC);
    chk_vec("sh_wdata", a_wd, 32'hBEEFBEEF);
    chk_vec("sh_rdata_kept", rdata, 32'hFFFFFF80);

    // misaligned word
    access(1'b0, 32'h06, 32'h0, 2'b10, 1'b0, 0, 1'b1, 1'b0, 32'h0);
    chk_vec("mis_err", 32'({a_done, a_err}), 32'h1);
    chk_vec("mis_breq", 32'(a_breq), 32'd0);
    chk_vec("mis_stall", 32'(a_stall), 32'd1);
    chk_vec("mis_rdata", rdata, 32'hFFFFFF80);

    // misaligned half and illegal size
    access(1'b0, 32'h01, 32'h0, 2'b01, 1'b0, 0, 1'b1, 1'b0, 32'h0);
    chk_vec("mish_err", 32'({a_done, a_err, 8'(a_breq)}), 32'h100);
    access(1'b0, 32'h00, 32'h0, 2'b11, 1'b0, 0, 1'b1, 1'b0, 32'h0);
    chk_vec("ill_err", 32'({a_done, a_err, 8'(a_breq)}), 32'h100);

    // timeout with no response
    access(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 0, 1'b0, 1'b0, 32'h0);
    chk_vec("to_err", 32'({a_done, a_err}), 32'h1);
    chk_vec("to_breq", 32'(a_breq), 32'd4);
    chk_vec("to_stall", 32'(a_stall), 32'd5);

    // ack and bus_err together: error wins, rdata untouched
    access(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 0, 1'b1, 1'b1, 32'h11111111);
    chk_vec("ackerr_err", 32'({a_done, a_err}), 32'h1);
    chk_vec("ackerr_breq", 32'(a_breq), 32'd1);
    chk_vec("ackerr_rdata", rdata, 32'hFFFFFF80);

    // bus error after one wait cycle
    access(1'b0, 32'h14, 32'h0, 2'b10, 1'b0, 1, 1'b0, 1'b1, 32'h22222222);
    chk_vec("berr_err", 32'({a_done, a_err, 8'(a_breq)}), 32'h102);

    // store byte lane 1
    access(1'b1, 32'h21, 32'h000000A5, 2'b00, 1'b0, 0, 1'b1, 1'b0, 32'h0);
    chk_vec("sb_be", 32'(a_be), 32'h2);
    chk_vec("sb_wdata", a_wd, 32'hA5A5A5A5);
    chk_vec("sb_adr", a_adr, 32'h20);

    // signed half low lane, unsigned byte lane 2
    access(1'b0, 32'h04, 32'h0, 2'b01, 1'b0, 0, 1'b1, 1'b0, 32'h12348001);
    chk_vec("lh_be", 32'(a_be), 32'h3);
    chk_vec("lh_rdata", rdata, 32'hFFFF8001);
    access(1'b0, 32'h102, 32'h0, 2'b00, 1'b1, 0, 1'b1, 1'b0, 32'h80AABBCC);
    chk_vec("lbu_be", 32'(a_be), 32'h4);
    chk_vec("lbu_rdata", rdata, 32'h000000AA);

    // reset asserted mid-transaction
    req_we = 1'b0; req_adr = 32'h40; req_size = 2'b10; req_unsigned = 1'b0; req_valid = 1'b1;
    tick();
    chk_vec("rst_mid_pre", 32'({bus_req, stall}), 32'h3);
    rst_n = 1'b0;
    #1;
    chk_vec("rst_mid_ctrl", 32'({bus_req, stall, done, err}), 32'h0);
    chk_vec("rst_mid_rdata", rdata, 32'h0);
    req_valid = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    chk_vec("rst_after_idle", 32'({bus_req, stall, done, err}), 32'h0);
    access(1'b0, 32'h44, 32'h0, 2'b10, 1'b0, 0, 1'b1, 1'b0, 32'h12345678);
    chk_vec("rst_after_done", 32'({a_done, a_err, 8'(a_breq)}), 32'h201);
    chk_vec("rst_after_rdata", rdata, 32'h12345678);

    // back-to-back loads (idle gap is checked inside access)
    access(1'b0, 32'h02, 32'h0, 2'b01, 1'b1, 0, 1'b1, 1'b0, 32'hF00D0000);
    chk_vec("b2b_lhu_rdata", rdata, 32'h0000F00D);
    access(1'b0, 32'h08, 32'h0, 2'b10, 1'b0, 0, 1'b1, 1'b0, 32'hCAFEF00D);
    chk_vec("b2b_lw_done", 32'({a_done, a_err}), 32'h2);
    chk_vec("b2b_lw_be", 32'(a_be), 32'hF);
    chk_vec("b2b_lw_rdata", rdata, 32'hCAFEF00D);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
